// File: rtl/sa_x_feeder.sv
// sa_x_feeder: input-edge feeder for a systolic array.
// Buffers X_R rows of S words and replays them into the array as skewed
// diagonal wavefronts (array row k sees X[r][k] on wavefront r+k). Each
// wavefront is held for STEP clocks to line up with the PE update cadence.
module sa_x_feeder #(
    parameter int unsigned S    = 64,
    parameter int unsigned X_R  = 64,
    parameter int unsigned STEP = 5,
    parameter int unsigned DW   = 16
) (
    input  logic                   I_CLK,
    input  logic                   I_RST,
    input  logic                   I_WR_EN,
    input  logic [$clog2(X_R)-1:0] I_WR_ADDR,
    input  logic [S*DW-1:0]        I_WR_DATA,
    input  logic                   I_START,
    output logic                   O_BUSY,
    output logic                   O_DONE,
    output logic                   O_STEP,
    output logic [S-1:0]           O_X_VLD,
    output logic [S*DW-1:0]        O_X_DATA
);

    localparam int unsigned AW = $clog2(X_R);
    localparam int unsigned T  = X_R + S - 1;          // wavefront count
    localparam int unsigned WW = $clog2(X_R + S);
    localparam int unsigned SW = (STEP > 1) ? $clog2(STEP) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FEED = 1'b1;

    logic [0:0]      state_q;
    logic [SW-1:0]   step_q;
    logic [WW-1:0]   wave_q;
    logic            busy_q;
    logic            done_q;
    logic            stp_q;
    logic [S-1:0]    vld_q;
    logic [S*DW-1:0] data_q;

    logic [S*DW-1:0] mem [X_R];

    logic [WW-1:0]   wave_nxt;
    logic            step_last;
    logic            wave_last;
    logic [S-1:0]    lane_vld;
    logic [S*DW-1:0] lane_data;
    logic            wr_ok;

    // Row writes land only while idle and not in the cycle a stream is launched.
    always_comb begin
        wr_ok = (state_q == IDLE) && !I_START && I_WR_EN && (int'(I_WR_ADDR) < int'(X_R));
    end

    // X row buffer; intentionally not cleared by reset so a replay sees the same data.
    always_ff @(posedge I_CLK) begin
        if (wr_ok) begin
            mem[I_WR_ADDR] <= I_WR_DATA;
        end
    end

    // Counter terminal conditions and the index of the wavefront to load next.
    always_comb begin
        step_last = (step_q == SW'(STEP - 1));
        wave_last = (wave_q == WW'(T - 1));
        wave_nxt  = (state_q == FEED) ? (wave_q + WW'(1)) : '0;
    end

    // Lane contents for wavefront wave_nxt: lane k carries row (wave_nxt - k) when that row exists.
    always_comb begin
        int rel;
        rel       = 0;
        lane_vld  = '0;
        lane_data = '0;
        for (int k = 0; k < int'(S); k++) begin
            rel = int'(wave_nxt) - k;
            if (rel >= 0 && rel < int'(X_R)) begin
                lane_vld[k]           = 1'b1;
                lane_data[k*DW +: DW] = mem[rel[AW-1:0]][k*DW +: DW];
            end
        end
    end

    // Control FSM, step/wavefront counters and registered outputs.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q <= IDLE;
            step_q  <= '0;
            wave_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stp_q   <= 1'b0;
            vld_q   <= '0;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            stp_q  <= 1'b0;
            if (state_q == IDLE) begin
                if (I_START) begin
                    state_q <= FEED;
                    step_q  <= '0;
                    wave_q  <= '0;
                    busy_q  <= 1'b1;
                    stp_q   <= 1'b1;
                    vld_q   <= lane_vld;
                    data_q  <= lane_data;
                end
            end else begin
                if (step_last) begin
                    step_q <= '0;
                    if (wave_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        vld_q   <= '0;
                        data_q  <= '0;
                    end else begin
                        wave_q <= wave_nxt;
                        stp_q  <= 1'b1;
                        vld_q  <= lane_vld;
                        data_q <= lane_data;
                    end
                end else begin
                    step_q <= step_q + SW'(1);
                end
            end
        end
    end

    // Drive ports straight from the output registers.
    always_comb begin
        O_BUSY   = busy_q;
        O_DONE   = done_q;
        O_STEP   = stp_q;
        O_X_VLD  = vld_q;
        O_X_DATA = data_q;
    end

endmodule

// File: tb/tb_sa_x_feeder.sv
// Directed bench for sa_x_feeder with S=4, X_R=3; one instance at STEP=5
// and one at STEP=1 sharing the reset and write bus.
module tb_sa_x_feeder;

    localparam int S  = 4;
    localparam int XR = 3;
    localparam int DW = 16;
    localparam int T  = XR + S - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [63:0]   wr_data;
    logic          start;
    logic          start1;

    logic          busy, done, stp;
    logic [3:0]    vld;
    logic [63:0]   xd;
    logic          busy1, done1, stp1;
    logic [3:0]    vld1;
    logic [63:0]   xd1;

    logic [15:0]   xm [XR][S];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sa_x_feeder #(.S(S), .X_R(XR), .STEP(5), .DW(DW)) dut (
        .I_CLK(clk), .I_RST(rst), .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr),
        .I_WR_DATA(wr_data), .I_START(start), .O_BUSY(busy), .O_DONE(done),
        .O_STEP(stp), .O_X_VLD(vld), .O_X_DATA(xd)
    );

    sa_x_feeder #(.S(S), .X_R(XR), .STEP(1), .DW(DW)) dut1 (
        .I_CLK(clk), .I_RST(rst), .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr),
        .I_WR_DATA(wr_data), .I_START(start1), .O_BUSY(busy1), .O_DONE(done1),
        .O_STEP(stp1), .O_X_VLD(vld1), .O_X_DATA(xd1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at 'off' cycles after the start-sampling cycle.
    task automatic calc_exp(input int off, input int step, output logic [70:0] e);
        logic        eb, edn, es;
        logic [3:0]  ev;
        logic [63:0] ed;
        int          t;
        eb = 1'b0; edn = 1'b0; es = 1'b0; ev = '0; ed = '0;
        if (off >= 1 && off <= T * step) begin
            eb = 1'b1;
            t  = (off - 1) / step;
            es = ((off - 1) % step) == 0;
            for (int k = 0; k < S; k++) begin
                if (t - k >= 0 && t - k < XR) begin
                    ev[k]           = 1'b1;
                    ed[k*16 +: 16]  = xm[t-k][k];
                end
            end
        end else if (off == T * step + 1) begin
            edn = 1'b1;
        end
        e = {eb, edn, es, ev, ed};
    endtask

    function automatic logic [63:0] pack_row(input int r);
        logic [63:0] d;
        for (int k = 0; k < S; k++) d[k*16 +: 16] = xm[r][k];
        return d;
    endfunction

    task automatic write_rows();
        for (int r = 0; r < XR; r++) begin
            wr_en = 1'b1; wr_addr = 2'(r); wr_data = pack_row(r);
            tick();
        end
        // Out-of-range row must not land anywhere.
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = {4{16'hDEAD}};
        tick();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'($urandom); wr_addr = 2'($urandom_range(0, 2));
            wr_data = {$urandom, $urandom}; start = 1'($urandom); start1 = 1'($urandom);
            tick();
            total++;
            if ({busy, done, stp, vld, xd} !== 71'd0) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h want=0", i, {busy, done, stp, vld, xd});
            end
            total++;
            if ({busy1, done1, stp1, vld1, xd1} !== 71'd0) begin
                bad++;
                $display("FAIL reset1 cyc=%0d got=%h want=0", i, {busy1, done1, stp1, vld1, xd1});
            end
        end
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; start1 = 1'b0;
    endtask

    task automatic test_normal();
        logic [70:0] e;
        write_rows();
        repeat (3) tick();
        pulse_start();
        for (int off = 1; off <= 32; off++) begin
            calc_exp(off, 5, e);
            total++;
            if ({busy, done, stp, vld, xd} !== e) begin
                bad++;
                $display("FAIL normal off=%0d got=%h want=%h", off, {busy, done, stp, vld, xd}, e);
            end
            if (off == 1) begin
                total++;
                if (!(stp === 1'b1 && vld === 4'b0001 && xd[15:0] === 16'h1000)) begin
                    bad++;
                    $display("FAIL normal_w0 got stp=%b vld=%b l0=%h want 1 0001 1000", stp, vld, xd[15:0]);
                end
            end
            if (off == 6) begin
                total++;
                if (!(vld === 4'b0011 && xd[31:0] === 32'h1001_1010)) begin
                    bad++;
                    $display("FAIL normal_w1 got vld=%b l1l0=%h want 0011 10011010", vld, xd[31:0]);
                end
            end
            if (off == 16) begin
                total++;
                if (!(vld === 4'b1110 && xd[63:16] === 48'h1003_1012_1021)) begin
                    bad++;
                    $display("FAIL normal_w3 got vld=%b l3..l1=%h want 1110 100310121021", vld, xd[63:16]);
                end
            end
            if (off == 26) begin
                total++;
                if (!(vld === 4'b1000 && xd[63:48] === 16'h1023)) begin
                    bad++;
                    $display("FAIL normal_w5 got vld=%b l3=%h want 1000 1023", vld, xd[63:48]);
                end
            end
            tick();
        end
    endtask

    task automatic test_ignore_busy();
        logic [70:0] e;
        repeat (2) tick();
        pulse_start();
        for (int off = 1; off <= 33; off++) begin
            calc_exp(off, 5, e);
            total++;
            if ({busy, done, stp, vld, xd} !== e) begin
                bad++;
                $display("FAIL busy_ign off=%0d got=%h want=%h", off, {busy, done, stp, vld, xd}, e);
            end
            if (off == 10) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = {4{16'hFFFF}};
            end else begin
                start = 1'b0; wr_en = 1'b0; wr_data = '0;
            end
            tick();
        end
        // Replay: row 0 must still hold the original data.
        pulse_start();
        total++;
        if (!(vld === 4'b0001 && xd[15:0] === 16'h1000)) begin
            bad++;
            $display("FAIL busy_rerun got vld=%b l0=%h want 0001 1000", vld, xd[15:0]);
        end
        repeat (35) tick();
    endtask

    task automatic test_reset_mid();
        logic [70:0] e;
        pulse_start();
        for (int off = 1; off <= 10; off++) begin
            calc_exp(off, 5, e);
            total++;
            if ({busy, done, stp, vld, xd} !== e) begin
                bad++;
                $display("FAIL rmid_pre off=%0d got=%h want=%h", off, {busy, done, stp, vld, xd}, e);
            end
            if (off == 10) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({busy, done, stp, vld, xd} !== 71'd0) begin
                bad++;
                $display("FAIL rmid_zero i=%0d got=%h want=0", i, {busy, done, stp, vld, xd});
            end
            tick();
        end
        pulse_start();
        total++;
        if (!(vld === 4'b0001 && xd[15:0] === 16'h1000)) begin
            bad++;
            $display("FAIL rmid_replay got vld=%b l0=%h want 0001 1000", vld, xd[15:0]);
        end
        for (int off = 1; off <= 31; off++) begin
            calc_exp(off, 5, e);
            total++;
            if ({busy, done, stp, vld, xd} !== e) begin
                bad++;
                $display("FAIL rmid_post off=%0d got=%h want=%h", off, {busy, done, stp, vld, xd}, e);
            end
            tick();
        end
    endtask

    task automatic test_sign();
        logic [70:0] e;
        xm[1][2] = 16'hE000;
        write_rows();
        pulse_start();
        for (int off = 1; off <= 31; off++) begin
            calc_exp(off, 5, e);
            total++;
            if ({busy, done, stp, vld, xd} !== e) begin
                bad++;
                $display("FAIL sign off=%0d got=%h want=%h", off, {busy, done, stp, vld, xd}, e);
            end
            if (off >= 16 && off <= 20) begin
                total++;
                if (!(vld[2] === 1'b1 && xd[47:32] === 16'hE000 && stp === (off == 16))) begin
                    bad++;
                    $display("FAIL sign_lane2 off=%0d got v=%b d=%h s=%b want 1 e000 %b",
                             off, vld[2], xd[47:32], stp, off == 16);
                end
            end
            tick();
        end
    endtask

    task automatic test_step1();
        logic [70:0] e;
        write_rows();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int off = 1; off <= 8; off++) begin
            calc_exp(off, 1, e);
            total++;
            if ({busy1, done1, stp1, vld1, xd1} !== e) begin
                bad++;
                $display("FAIL step1 off=%0d got=%h want=%h", off, {busy1, done1, stp1, vld1, xd1}, e);
            end
            if (off <= 6) begin
                total++;
                if (stp1 !== 1'b1) begin
                    bad++;
                    $display("FAIL step1_stp off=%0d got=%b want=1", off, stp1);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int r = 0; r < XR; r++)
            for (int k = 0; k < S; k++)
                xm[r][k] = 16'(16'h1000 + r * 16 + k);
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; start1 = 1'b0;
        #1;
        test_reset();
        test_normal();
        test_ignore_busy();
        test_reset_mid();
        test_sign();
        test_step1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
